// File: rtl/ahb_line_queue.sv
// AHB-Lite slave that queues line-draw commands and hands them one at a time
// to the line engine over a valid/ready handshake, stalling the bus when full.
module ahb_line_queue #(
   parameter int DEPTH   = 4,
   parameter int COORD_W = 9
) (
   input  logic               HCLK,
   input  logic               HRESETn,
   input  logic               HSEL,
   input  logic [31:0]        HADDR,
   input  logic [1:0]         HTRANS,
   input  logic [2:0]         HSIZE,
   input  logic               HWRITE,
   input  logic [31:0]        HWDATA,
   input  logic               HREADY,
   output logic [31:0]        HRDATA,
   output logic               HREADYOUT,
   output logic [COORD_W-1:0] x1,
   output logic [COORD_W-1:0] y1,
   output logic [COORD_W-1:0] x2,
   output logic [COORD_W-1:0] y2,
   output logic               DataValid,
   input  logic               DataReady
);

   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int ENTRY_W = 4 * COORD_W;

   localparam logic [1:0] ADDR_START  = 2'd0;
   localparam logic [1:0] ADDR_END    = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic               dp_valid_q, dp_valid_d;
   logic               dp_write_q, dp_write_d;
   logic               dp_size_ok_q, dp_size_ok_d;
   logic [1:0]         dp_addr_q, dp_addr_d;
   logic [COORD_W-1:0] stage_x_q, stage_x_d;
   logic [COORD_W-1:0] stage_y_q, stage_y_d;
   logic               enable_q, enable_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [ENTRY_W-1:0] mem_d [DEPTH];

   logic full;
   logic end_write_pending;
   logic wr_fire;
   logic push;
   logic pop;
   logic flush;
   logic unused_ok;

   assign unused_ok = ^{HADDR, HTRANS, HWDATA};

   assign full              = (count_q == CNT_FULL);
   assign end_write_pending = dp_valid_q & dp_write_q & dp_size_ok_q & (dp_addr_q == ADDR_END);
   assign HREADYOUT         = !(end_write_pending & full);
   assign DataValid         = enable_q & (count_q != '0);
   assign {x1, y1, x2, y2}  = mem_q[rd_ptr_q];

   assign wr_fire = dp_valid_q & dp_write_q & dp_size_ok_q & HREADYOUT;
   assign push    = wr_fire & (dp_addr_q == ADDR_END);
   assign flush   = wr_fire & (dp_addr_q == ADDR_CTRL) & HWDATA[1];
   assign pop     = DataValid & DataReady;

   // The address phase is held while the bus is stalled so a pending END survives.
   always_comb begin
      dp_valid_d   = dp_valid_q;
      dp_write_d   = dp_write_q;
      dp_size_ok_d = dp_size_ok_q;
      dp_addr_d    = dp_addr_q;
      if (HREADY) begin
         dp_valid_d   = HSEL & HTRANS[1];
         dp_write_d   = HWRITE;
         dp_size_ok_d = (HSIZE == 3'b010);
         dp_addr_d    = HADDR[3:2];
      end
   end

   always_comb begin
      stage_x_d = stage_x_q;
      stage_y_d = stage_y_q;
      enable_d  = enable_q;
      if (wr_fire && dp_addr_q == ADDR_START) begin
         stage_x_d = HWDATA[COORD_W-1:0];
         stage_y_d = HWDATA[16 +: COORD_W];
      end
      if (wr_fire && dp_addr_q == ADDR_CTRL) begin
         enable_d = HWDATA[0];
      end
   end

   // Flush wins over a same-cycle pop; it can never coincide with a push.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = {stage_x_q, stage_y_q, HWDATA[COORD_W-1:0], HWDATA[16 +: COORD_W]};
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
         count_d = count_q - CNT_ONE;
      end
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_comb begin
      HRDATA = '0;
      if (dp_valid_q && !dp_write_q) begin
         case (dp_addr_q)
            ADDR_START: begin
               HRDATA[COORD_W-1:0]  = stage_x_q;
               HRDATA[16 +: COORD_W] = stage_y_q;
            end
            ADDR_STATUS: begin
               HRDATA[0]         = (count_q == '0);
               HRDATA[1]         = full;
               HRDATA[2]         = DataValid;
               HRDATA[4 +: CNT_W] = count_q;
            end
            ADDR_CTRL: begin
               HRDATA[0] = enable_q;
            end
            default: begin
               HRDATA = '0;
            end
         endcase
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         dp_valid_q   <= 1'b0;
         dp_write_q   <= 1'b0;
         dp_size_ok_q <= 1'b0;
         dp_addr_q    <= '0;
         stage_x_q    <= '0;
         stage_y_q    <= '0;
         enable_q     <= 1'b1;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         dp_valid_q   <= dp_valid_d;
         dp_write_q   <= dp_write_d;
         dp_size_ok_q <= dp_size_ok_d;
         dp_addr_q    <= dp_addr_d;
         stage_x_q    <= stage_x_d;
         stage_y_q    <= stage_y_d;
         enable_q     <= enable_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule

// File: tb/tb_ahb_line_queue.sv
// Directed bench for ahb_line_queue: bus tasks drive single AHB transfers and
// each scenario task checks its own hand-computed expectations.
module tb_ahb_line_queue;

   localparam int DEPTH   = 4;
   localparam int COORD_W = 9;

   logic               HCLK = 1'b0;
   logic               HRESETn;
   logic               HSEL;
   logic [31:0]        HADDR;
   logic [1:0]         HTRANS;
   logic [2:0]         HSIZE;
   logic               HWRITE;
   logic [31:0]        HWDATA;
   wire                HREADY;
   logic [31:0]        HRDATA;
   logic               HREADYOUT;
   logic [COORD_W-1:0] x1, y1, x2, y2;
   logic               DataValid;
   logic               DataReady;

   int n_cmp  = 0;
   int n_fail = 0;

   assign HREADY = HREADYOUT;

   ahb_line_queue #(.DEPTH(DEPTH), .COORD_W(COORD_W)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
      .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
      .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
      .x1(x1), .y1(y1), .x2(x2), .y2(y2),
      .DataValid(DataValid), .DataReady(DataReady)
   );

   always #5 HCLK = ~HCLK;

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic addr_phase(input logic [3:0] addr, input logic wr, input logic [2:0] size);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HADDR  = {28'h0, addr};
      HWRITE = wr;
      HSIZE  = size;
   endtask

   task automatic bus_idle();
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (HREADYOUT !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      if (n >= 64) begin
         n_cmp++;
         n_fail++;
         $display("[TB] FAIL wait_ready: HREADYOUT stuck at %b, required 1 within 64 cycles", HREADYOUT);
      end
   endtask

   task automatic ahb_write(input logic [3:0] addr, input logic [31:0] data, input logic [2:0] size);
      addr_phase(addr, 1'b1, size);
      tick();
      bus_idle();
      HWDATA = data;
      wait_ready();
      tick();
   endtask

   task automatic ahb_read(input logic [3:0] addr, output logic [31:0] data);
      addr_phase(addr, 1'b0, 3'b010);
      tick();
      bus_idle();
      @(negedge HCLK);
      data = HRDATA;
      @(posedge HCLK);
      #1;
   endtask

   function automatic logic [31:0] end_word(input int x, input int y);
      return (32'(y) << 16) | 32'(x);
   endfunction

   task automatic do_reset();
      HRESETn = 1'b0;
      tick();
      tick();
      HRESETn = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      bus_idle();
      HADDR = '0; HSIZE = 3'b010; HWDATA = '0; DataReady = 1'b0;
      do_reset();
      n_cmp++;
      if (DataValid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b, required 0", DataValid); end
      n_cmp++;
      if (HREADYOUT !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_readyout: got %b, required 1", HREADYOUT); end
      n_cmp++;
      if ({x1, y1, x2, y2} !== '0) begin n_fail++; $display("[TB] FAIL reset_coords: got %h, required 0", {x1, y1, x2, y2}); end
      n_cmp++;
      if (HRDATA !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_hrdata: got %h, required 0", HRDATA); end
      ahb_read(4'h8, rd);
      n_cmp++;
      if (rd !== 32'h0000_0001) begin n_fail++; $display("[TB] FAIL reset_status: got %h, required 00000001", rd); end
   endtask

   task automatic test_single();
      logic [31:0] rd;
      DataReady = 1'b1;
      ahb_write(4'h0, 32'h0014_000A, 3'b010);
      ahb_write(4'h4, 32'h0028_001E, 3'b010);
      n_cmp++;
      if (DataValid !== 1'b1 || x1 !== 9'd10 || y1 !== 9'd20 || x2 !== 9'd30 || y2 !== 9'd40) begin
         n_fail++;
         $display("[TB] FAIL single_head: got valid=%b %0d,%0d,%0d,%0d, required valid=1 10,20,30,40",
                  DataValid, x1, y1, x2, y2);
      end
      ahb_read(4'h8, rd);
      n_cmp++;
      if (rd !== 32'h0000_0001) begin n_fail++; $display("[TB] FAIL single_status: got %h, required 00000001", rd); end
      ahb_read(4'h0, rd);
      n_cmp++;
      if (rd !== 32'h0014_000A) begin n_fail++; $display("[TB] FAIL start_readback: got %h, required 0014000A", rd); end
      ahb_read(4'h4, rd);
      n_cmp++;
      if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL end_readback: got %h, required 0", rd); end
      DataReady = 1'b0;
   endtask

   task automatic test_full_stall();
      logic [31:0] rd;
      DataReady = 1'b0;
      ahb_write(4'h0, 32'h0005_0003, 3'b010);
      for (int k = 1; k <= 4; k++) ahb_write(4'h4, end_word(k, k + 100), 3'b010);
      ahb_read(4'h8, rd);
      n_cmp++;
      if (rd !== 32'h0000_0046) begin n_fail++; $display("[TB] FAIL full_status: got %h, required 00000046", rd); end
      addr_phase(4'h4, 1'b1, 3'b010);
      tick();
      bus_idle();
      HWDATA = end_word(5, 105);
      n_cmp++;
      if (HREADYOUT !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_first: got %b, required 0", HREADYOUT); end
      tick();
      n_cmp++;
      if (HREADYOUT !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_held: got %b, required 0", HREADYOUT); end
      DataReady = 1'b1;
      n_cmp++;
      if (HREADYOUT !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_ready_comb: got %b, required 0", HREADYOUT); end
      tick();
      DataReady = 1'b0;
      n_cmp++;
      if (HREADYOUT !== 1'b1 || x2 !== 9'd2) begin
         n_fail++;
         $display("[TB] FAIL stall_release: got readyout=%b x2=%0d, required 1 and 2", HREADYOUT, x2);
      end
      tick();
      ahb_read(4'h8, rd);
      n_cmp++;
      if (rd !== 32'h0000_0046) begin n_fail++; $display("[TB] FAIL refill_status: got %h, required 00000046", rd); end
      DataReady = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         n_cmp++;
         if (DataValid !== 1'b1 || x1 !== 9'd3 || y1 !== 9'd5 || x2 !== 9'(k) || y2 !== 9'(k + 100)) begin
            n_fail++;
            $display("[TB] FAIL fifo_order_%0d: got valid=%b %0d,%0d,%0d,%0d, required valid=1 3,5,%0d,%0d",
                     k, DataValid, x1, y1, x2, y2, k, k + 100);
         end
         tick();
      end
      DataReady = 1'b0;
      n_cmp++;
      if (DataValid !== 1'b0) begin n_fail++; $display("[TB] FAIL drained_valid: got %b, required 0", DataValid); end
   endtask

   task automatic test_flush();
      logic [31:0] rd;
      DataReady = 1'b0;
      for (int k = 1; k <= 3; k++) ahb_write(4'h4, end_word(k + 20, k), 3'b010);
      addr_phase(4'hC, 1'b1, 3'b010);
      tick();
      bus_idle();
      HWDATA = 32'h3;
      DataReady = 1'b1;
      tick();
      DataReady = 1'b0;
      n_cmp++;
      if (DataValid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_valid: got %b, required 0", DataValid); end
      ahb_read(4'h8, rd);
      n_cmp++;
      if (rd !== 32'h0000_0001) begin n_fail++; $display("[TB] FAIL flush_status: got %h, required 00000001", rd); end
      ahb_read(4'hC, rd);
      n_cmp++;
      if (rd !== 32'h0000_0001) begin n_fail++; $display("[TB] FAIL flush_control: got %h, required 00000001", rd); end
   endtask

   task automatic test_enable();
      logic [31:0] rd;
      DataReady = 1'b0;
      ahb_write(4'h4, end_word(17, 1), 3'b010);
      ahb_write(4'h4, end_word(18, 2), 3'b010);
      ahb_write(4'hC, 32'h0, 3'b010);
      n_cmp++;
      if (DataValid !== 1'b0) begin n_fail++; $display("[TB] FAIL disable_valid: got %b, required 0", DataValid); end
      DataReady = 1'b1;
      ahb_read(4'h8, rd);
      n_cmp++;
      if (rd !== 32'h0000_0020) begin n_fail++; $display("[TB] FAIL disabled_status: got %h, required 00000020", rd); end
      ahb_write(4'h4, end_word(99, 99), 3'b000);
      ahb_read(4'h8, rd);
      n_cmp++;
      if (rd !== 32'h0000_0020) begin n_fail++; $display("[TB] FAIL byte_write_status: got %h, required 00000020", rd); end
      DataReady = 1'b0;
      ahb_write(4'hC, 32'h1, 3'b010);
      DataReady = 1'b1;
      for (int k = 17; k <= 18; k++) begin
         n_cmp++;
         if (DataValid !== 1'b1 || x2 !== 9'(k)) begin
            n_fail++;
            $display("[TB] FAIL reenable_order_%0d: got valid=%b x2=%0d, required 1 and %0d", k, DataValid, x2, k);
         end
         tick();
      end
      DataReady = 1'b0;
      n_cmp++;
      if (DataValid !== 1'b0) begin n_fail++; $display("[TB] FAIL reenable_drained: got %b, required 0", DataValid); end
   endtask

   task automatic test_wrap();
      int idx;
      int cyc;
      ahb_write(4'h0, 32'h0002_0001, 3'b010);
      idx = 0;
      cyc = 0;
      fork
         begin
            for (int k = 0; k < 3 * DEPTH; k++) ahb_write(4'h4, end_word(k + 7, 2 * k + 1), 3'b010);
         end
         begin
            while (idx < 3 * DEPTH && cyc < 3000) begin
               @(negedge HCLK);
               if (DataValid && DataReady) begin
                  n_cmp++;
                  if (x1 !== 9'd1 || y1 !== 9'd2 || x2 !== 9'(idx + 7) || y2 !== 9'(2 * idx + 1)) begin
                     n_fail++;
                     $display("[TB] FAIL wrap_%0d: got %0d,%0d,%0d,%0d, required 1,2,%0d,%0d",
                              idx, x1, y1, x2, y2, idx + 7, 2 * idx + 1);
                  end
                  idx++;
               end
               @(posedge HCLK);
               #1;
               DataReady = 1'($urandom_range(0, 1));
               cyc++;
            end
         end
      join
      DataReady = 1'b0;
      n_cmp++;
      if (idx != 3 * DEPTH) begin n_fail++; $display("[TB] FAIL wrap_count: got %0d delivered, required %0d", idx, 3 * DEPTH); end
   endtask

   task automatic test_reset_stall();
      logic [31:0] rd;
      DataReady = 1'b0;
      for (int k = 1; k <= 4; k++) ahb_write(4'h4, end_word(k + 40, k), 3'b010);
      addr_phase(4'h4, 1'b1, 3'b010);
      tick();
      bus_idle();
      HWDATA = end_word(50, 50);
      n_cmp++;
      if (HREADYOUT !== 1'b0) begin n_fail++; $display("[TB] FAIL pre_reset_stall: got %b, required 0", HREADYOUT); end
      HRESETn = 1'b0;
      tick();
      HRESETn = 1'b1;
      n_cmp++;
      if (HREADYOUT !== 1'b1 || DataValid !== 1'b0 || {x1, y1, x2, y2} !== '0 || HRDATA !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_in_stall: got readyout=%b valid=%b coords=%h hrdata=%h, required 1 0 0 0",
                  HREADYOUT, DataValid, {x1, y1, x2, y2}, HRDATA);
      end
      ahb_read(4'h8, rd);
      n_cmp++;
      if (rd !== 32'h0000_0001) begin n_fail++; $display("[TB] FAIL post_reset_status: got %h, required 00000001", rd); end
   endtask

   initial begin
      HRESETn = 1'b0;
      #1;
      test_reset();
      test_single();
      test_full_stall();
      test_flush();
      test_enable();
      test_wrap();
      test_reset_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_line_queue.md
# ahb_line_queue

AHB-Lite slave that queues line-draw commands written by the Cortex-M0 and sequences them, one at a time, to the downstream line-drawing engine over a valid/ready handshake. It sits on the AHB interconnect as an extra slave (own HSEL, HRDATA, HREADYOUT) and decouples software issue rate from engine drawing rate. When the queue is full it inserts AHB wait states instead of dropping commands.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- COORD_W, 9, coordinate width
- HCLK  in  1  system clock; all state updates on rising edge
- HRESETn  in  1  synchronous active-low reset, sampled on rising HCLK
- HSEL  in  1  slave select from interconnect
- HADDR  in  32  address; only HADDR[3:2] decoded
- HTRANS  in  2  transfer type; HTRANS[1]=1 means active
- HSIZE  in  3  transfer size; only 3'b010 writes take effect
- HWRITE  in  1  write/read
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus ready
- HRDATA  out  32  read data (data phase)
- HREADYOUT  out  1  low = wait state
- x1, y1, x2, y2  out  COORD_W  head-entry coordinates
- DataValid  out  1  head entry offered to engine
- DataReady  in  1  engine accepts head entry

## Operation
- Address phase is captured when HSEL & HREADY & HTRANS[1]. Captured state: address bits [3:2], write flag, size-ok flag. The access executes in the following data phase.
- Register map (byte offset):
  - 0x0 START: write sets staging {y1=HWDATA[24:16], x1=HWDATA[8:0]}. Read returns staging in the same layout.
  - 0x4 END: write pushes {x1,y1 from staging, x2=HWDATA[8:0], y2=HWDATA[24:16]}. Read returns 0.
  - 0x8 STATUS (read-only): bit0 empty, bit1 full, bit2 DataValid, bits[8:4] count. Writes are ignored.
  - 0xC CONTROL: bit0 enable (R/W). Writing 1 to bit1 flushes the queue; bit1 always reads 0.
- Writes with HSIZE≠3'b010 are ignored. No error response; HRESP stays OKAY at SoC level.
- Staging is not cleared by a push. Several ENDs may follow one START.
- Queue is a circular buffer with rd_ptr, wr_ptr and count (0..DEPTH). Pointers wrap modulo DEPTH.
- Pop occurs when DataValid & DataReady.
- DataValid = enable & (count≠0).
- x1..y2 always show the head entry and are held stable while DataValid & !DataReady.
- Clearing enable deasserts DataValid on the next cycle and does not alter the queue. Pushes are still accepted while disabled.
- Flush: rd_ptr=wr_ptr=0, count=0 at the end of the CONTROL write data phase. Flush takes priority over a same-cycle pop.
- Reset values: count=0, pointers=0, staging=0, enable=1, DataValid=0, x1..y2=0, HRDATA=0, HREADYOUT=1.

## Timing
- HREADYOUT = !(data-phase END write & count==DEPTH). It is combinational from registered state only; DataReady must not feed HREADYOUT.
- Push occurs on the edge ending an END data phase with HREADYOUT=1.
- Full queue, END pending: the queue stalls while full. A pop at edge N makes count=DEPTH-1. HREADYOUT rises in cycle N+1 and the push happens at edge N+1. The minimum stall equals the number of cycles the queue remains full.
- Simultaneous push and pop (count not full): count unchanged, both pointers advance.
- Push into an empty enabled queue: DataValid is asserted in the cycle after the push edge (1-cycle latency). The entry is never visible in the same cycle it is written.
- Reads return data in the data-phase cycle, sampled from current state. A STATUS read in the cycle after a push reflects the push.
- Reset asserted mid-stall: HREADYOUT returns to 1 in the cycle following the reset edge and the pending write is discarded.
- One transfer completes per cycle with zero wait states whenever not full.

## Test plan
- Reset, then read STATUS -> 0x0000_0001 (empty). DataValid=0, HREADYOUT=1.
- Write START=0x0014_000A, then END=0x0028_001E, DataReady=1 -> one cycle after the END push, DataValid=1 with x1=10, y1=20, x2=30, y2=40. Pop happens on the next edge; STATUS then reads empty.
- DataReady=0, push 4 commands, then a 5th END -> STATUS count=4 with full=1. The 5th END stalls with HREADYOUT=0. Pulse DataReady for one cycle -> HREADYOUT=1 in the following cycle and count returns to 4. Head order is FIFO.
- Fill 3 entries, write CONTROL=0x3 (flush) in the same cycle as a DataReady pop -> count=0, DataValid=0 the next cycle, enable stays 1.
- Write CONTROL=0x0 with 2 queued -> DataValid falls; the queue holds 2. Re-enable -> entries emerge in order. Byte write (HSIZE=0) to END -> no push.
- Wrap-around: stream 3×DEPTH commands with random DataReady -> every command is delivered exactly once, in order. Assert HRESETn=0 during a full stall -> all outputs take their reset values one edge later.
